truth_table_scanner: RTL and testbench



---
 rtl/truth_table_scanner_if.sv | 26 ++
 rtl/truth_table_scanner.sv | 94 +++++++++
 tb/tb_truth_table_scanner.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_scanner_if.sv
// Handshake and data bundle between the truth-table scanner and the testbench driving it.
// The scanner takes the slave side.
interface truth_table_scanner_if #(
  parameter int N = 3
) ();
  logic                  start;
  logic [(1 << N) - 1:0] expected;
  logic [N - 1:0]        vec_out;
  logic                  dut_in;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [(1 << N) - 1:0] captured;
  logic [N:0]            fail_count;
  logic [N - 1:0]        first_fail;

  modport master (
    output start, expected, dut_in,
    input  vec_out, busy, done, pass, captured, fail_count, first_fail
  );

  modport slave (
    input  start, expected, dut_in,
    output vec_out, busy, done, pass, captured, fail_count, first_fail
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Sweeps every input vector of an N-input boolean function. It captures the responses
// into a minterm mask and compares that mask against an expected mask latched at start.
module truth_table_scanner #(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  truth_table_scanner_if.slave   bus
);
  localparam int M  = 1 << N;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  vec;
  logic [CW-1:0] cnt;
  logic [M-1:0]  exp_latch;
  logic [M-1:0]  captured;
  logic [N:0]    fail_count;
  logic [N-1:0]  first_fail;
  logic          pass;

  logic          sample;
  logic          mismatch;
  logic          last;
  logic [N:0]    fail_next;

  // The final sample feeds pass through fail_next, so pass is valid in the same cycle as done.
  always_comb begin
    sample    = (state == SCAN) && (cnt == CW'(SETTLE - 1));
    mismatch  = (bus.dut_in != exp_latch[vec]);
    last      = (vec == {N{1'b1}});
    fail_next = fail_count + {{N{1'b0}}, mismatch};
  end

  assign bus.vec_out    = (state == SCAN) ? vec : '0;
  assign bus.busy       = (state == SCAN);
  assign bus.done       = (state == DONE);
  assign bus.pass       = pass;
  assign bus.captured   = captured;
  assign bus.fail_count = fail_count;
  assign bus.first_fail = first_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      exp_latch  <= '0;
      captured   <= '0;
      fail_count <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp_latch  <= bus.expected;
            captured   <= '0;
            fail_count <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            vec        <= '0;
            cnt        <= '0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (sample) begin
            captured[vec] <= bus.dut_in;
            fail_count    <= fail_next;
            if (mismatch && (fail_count == '0))
              first_fail <= vec;
            cnt <= '0;
            if (last) begin
              pass  <= (fail_next == '0);
              state <= DONE;
            end else begin
              vec <= vec + N'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: three instances (N=3/SETTLE=1, N=3/SETTLE=3, N=4/SETTLE=1)
// driven by behavioural models of the lab equations, with hand-computed masks.
module tb_truth_table_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  truth_table_scanner_if #(.N(3)) bus_a ();
  truth_table_scanner_if #(.N(3)) bus_b ();
  truth_table_scanner_if #(.N(4)) bus_c ();

  truth_table_scanner #(.N(3), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  truth_table_scanner #(.N(3), .SETTLE(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  truth_table_scanner #(.N(4), .SETTLE(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0]  exp_a = '0, exp_b = '0;
  logic [15:0] exp_c = '0;
  int          mode_a = 0, mode_b = 2, mode_c = 0;

  // Modes: 0 = A(~B+C), 1 = (~A+B)(~C+B), 2 = ~B, other = stuck at 0
  function automatic logic f3(input int mode, input logic [2:0] v);
    case (mode)
      0:       return v[2] & (~v[1] | v[0]);
      1:       return (~v[2] | v[1]) & (~v[0] | v[1]);
      2:       return ~v[1];
      default: return 1'b0;
    endcase
  endfunction

  // Mode 0 is the even-parity function with minterms 0,3,5,6,9,10,12,15
  function automatic logic f4(input int mode, input logic [3:0] v);
    if (mode == 0) return ~^v;
    return 1'b0;
  endfunction

  assign bus_a.start    = start_a;
  assign bus_a.expected = exp_a;
  assign bus_a.dut_in   = f3(mode_a, bus_a.vec_out);
  assign bus_b.start    = start_b;
  assign bus_b.expected = exp_b;
  assign bus_b.dut_in   = f3(mode_b, bus_b.vec_out);
  assign bus_c.start    = start_c;
  assign bus_c.expected = exp_c;
  assign bus_c.dut_in   = f4(mode_c, bus_c.vec_out);

  typedef struct {
    int         mode;
    logic [7:0] expected;
    logic [7:0] cap;
    logic [3:0] fc;
    logic [2:0] ff;
    logic       ps;
  } vec_t;

  vec_t tbl[7];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  function automatic logic sel_done(input int w);
    case (w)
      0:       return bus_a.done;
      1:       return bus_b.done;
      default: return bus_c.done;
    endcase
  endfunction

  function automatic logic sel_busy(input int w);
    case (w)
      0:       return bus_a.busy;
      1:       return bus_b.busy;
      default: return bus_c.busy;
    endcase
  endfunction

  // Pulses start, returns start-to-done latency in cycles and leaves the instance back in IDLE.
  task automatic apply_stimulus(input int which, input int mode, input logic [15:0] expv, output int lat);
    lat = -1;
    @(negedge clk);
    case (which)
      0:       begin mode_a = mode; exp_a = expv[7:0]; start_a = 1'b1; end
      1:       begin mode_b = mode; exp_b = expv[7:0]; start_b = 1'b1; end
      default: begin mode_c = mode; exp_c = expv;      start_c = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    check_output("busy at start edge", 32'(sel_busy(which)), 32'd1);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (sel_done(which)) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) check_output("done timeout", 32'd0, 32'd1);
    else check_output("busy low with done", 32'(sel_busy(which)), 32'd0);
    @(posedge clk);
    #1;
    check_output("done one cycle", 32'(sel_done(which)), 32'd0);
  endtask

  initial begin
    int lat;
    int vec_err;
    int hits;
    logic [19:0] busy_seq, done_seq;

    tbl[0] = '{0, 8'hB0, 8'hB0, 4'd0, 3'd0, 1'b1};
    tbl[1] = '{1, 8'hCD, 8'hCD, 4'd0, 3'd0, 1'b1};
    tbl[2] = '{1, 8'hCF, 8'hCD, 4'd1, 3'd1, 1'b0};
    tbl[3] = '{2, 8'h33, 8'h33, 4'd0, 3'd0, 1'b1};
    tbl[4] = '{3, 8'hFF, 8'h00, 4'd8, 3'd0, 1'b0};
    tbl[5] = '{0, 8'h00, 8'hB0, 4'd3, 3'd4, 1'b0};
    tbl[6] = '{2, 8'hCC, 8'h33, 4'd8, 3'd0, 1'b0};

    #12;
    check_output("reset busy", 32'(bus_a.busy), 32'd0);
    check_output("reset done", 32'(bus_a.done), 32'd0);
    check_output("reset vec_out", 32'(bus_a.vec_out), 32'd0);
    check_output("reset pass", 32'(bus_a.pass), 32'd0);
    check_output("reset captured", 32'(bus_c.captured), 32'd0);
    check_output("reset fail_count", 32'(bus_c.fail_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(0, tbl[i].mode, {8'h00, tbl[i].expected}, lat);
      check_output($sformatf("t%0d latency", i), 32'(lat), 32'd8);
      check_output($sformatf("t%0d captured", i), 32'(bus_a.captured), 32'(tbl[i].cap));
      check_output($sformatf("t%0d fail_count", i), 32'(bus_a.fail_count), 32'(tbl[i].fc));
      check_output($sformatf("t%0d first_fail", i), 32'(bus_a.first_fail), 32'(tbl[i].ff));
      check_output($sformatf("t%0d pass", i), 32'(bus_a.pass), 32'(tbl[i].ps));
    end

    // start held high: scans begin at cycles 0 and 10, done at 8 and 18
    @(negedge clk);
    mode_a = 0; exp_a = 8'hB0; start_a = 1'b1;
    vec_err = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      busy_seq[c] = bus_a.busy;
      done_seq[c] = bus_a.done;
      if (c < 8 && bus_a.vec_out != 3'(c)) vec_err++;
    end
    @(negedge clk);
    start_a = 1'b0;
    check_output("held start busy", 32'(busy_seq), 32'h3FCFF);
    check_output("held start done", 32'(done_seq), 32'h40100);
    check_output("held start vec seq", 32'(vec_err), 32'd0);
    check_output("held start pass", 32'(bus_a.pass), 32'd1);
    repeat (2) @(posedge clk);

    // expected changed mid-scan must not affect the result
    @(negedge clk);
    mode_a = 0; exp_a = 8'hB0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    exp_a = 8'h00;
    hits = 0;
    for (int c = 0; c < 50 && hits == 0; c++) begin
      @(posedge clk);
      #1;
      if (bus_a.done) hits = 1;
    end
    check_output("mid-change done seen", 32'(hits), 32'd1);
    check_output("mid-change pass", 32'(bus_a.pass), 32'd1);
    check_output("mid-change fail_count", 32'(bus_a.fail_count), 32'd0);
    @(posedge clk);

    // asynchronous reset during vector 5
    @(negedge clk);
    mode_a = 0; exp_a = 8'hB0; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_output("pre-reset vec_out", 32'(bus_a.vec_out), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check_output("async vec_out", 32'(bus_a.vec_out), 32'd0);
    check_output("async busy", 32'(bus_a.busy), 32'd0);
    check_output("async captured", 32'(bus_a.captured), 32'd0);
    check_output("async fail_count", 32'(bus_a.fail_count), 32'd0);
    check_output("async first_fail", 32'(bus_a.first_fail), 32'd0);
    check_output("async pass", 32'(bus_a.pass), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (bus_a.done || bus_a.busy) hits++;
    end
    check_output("post-reset idle", 32'(hits), 32'd0);
    apply_stimulus(0, 0, 16'h00B0, lat);
    check_output("post-reset latency", 32'(lat), 32'd8);
    check_output("post-reset captured", 32'(bus_a.captured), 32'hB0);
    check_output("post-reset pass", 32'(bus_a.pass), 32'd1);

    // SETTLE=3: each vector held three cycles, done 24 cycles after start
    @(negedge clk);
    mode_b = 2; exp_b = 8'h33; start_b = 1'b1;
    vec_err = 0;
    for (int c = 0; c <= 24; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) start_b = 1'b0;
      if (c < 24) begin
        if (bus_b.vec_out != 3'(c / 3) || !bus_b.busy || bus_b.done) vec_err++;
      end
    end
    check_output("settle3 vec seq", 32'(vec_err), 32'd0);
    check_output("settle3 done at 24", 32'(bus_b.done), 32'd1);
    check_output("settle3 busy at 24", 32'(bus_b.busy), 32'd0);
    check_output("settle3 captured", 32'(bus_b.captured), 32'h33);
    check_output("settle3 pass", 32'(bus_b.pass), 32'd1);
    @(posedge clk);

    // four-input parity function
    apply_stimulus(2, 0, 16'h9669, lat);
    check_output("n4 latency", 32'(lat), 32'd16);
    check_output("n4 captured", 32'(bus_c.captured), 32'h9669);
    check_output("n4 fail_count", 32'(bus_c.fail_count), 32'd0);
    check_output("n4 pass", 32'(bus_c.pass), 32'd1);
    apply_stimulus(2, 1, 16'h9669, lat);
    check_output("n4 zero captured", 32'(bus_c.captured), 32'h0000);
    check_output("n4 zero fail_count", 32'(bus_c.fail_count), 32'd8);
    check_output("n4 zero first_fail", 32'(bus_c.first_fail), 32'd0);
    check_output("n4 zero pass", 32'(bus_c.pass), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
